// File: rtl/ddr_app_arbiter_if.sv
// Request-side and MIG app-side signal bundle for ddr_app_arbiter.
// slave: the arbiter's view; master: the requesters plus the MIG user port.
interface ddr_app_arbiter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);
  logic                  i_init_calib_complete;

  logic                  i_p0_req;
  logic                  i_p0_we;
  logic [ADDR_WIDTH-1:0] i_p0_addr;
  logic [DATA_WIDTH-1:0] i_p0_wdata;
  logic [MASK_WIDTH-1:0] i_p0_wmask;
  logic                  o_p0_gnt;
  logic [DATA_WIDTH-1:0] o_p0_rdata;
  logic                  o_p0_rvalid;
  logic                  o_p0_wdone;

  logic                  i_p1_req;
  logic                  i_p1_we;
  logic [ADDR_WIDTH-1:0] i_p1_addr;
  logic [DATA_WIDTH-1:0] i_p1_wdata;
  logic [MASK_WIDTH-1:0] i_p1_wmask;
  logic                  o_p1_gnt;
  logic [DATA_WIDTH-1:0] o_p1_rdata;
  logic                  o_p1_rvalid;
  logic                  o_p1_wdone;

  logic                  o_busy;

  logic [ADDR_WIDTH-1:0] o_app_addr;
  logic [2:0]            o_app_cmd;
  logic                  o_app_en;
  logic                  i_app_rdy;
  logic [DATA_WIDTH-1:0] o_app_wdf_data;
  logic [MASK_WIDTH-1:0] o_app_wdf_mask;
  logic                  o_app_wdf_wren;
  logic                  o_app_wdf_end;
  logic                  i_app_wdf_rdy;
  logic [DATA_WIDTH-1:0] i_app_rd_data;
  logic                  i_app_rd_data_valid;
  logic                  i_app_rd_data_end;

  modport slave (
    input  i_init_calib_complete,
    input  i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata, i_p0_wmask,
    output o_p0_gnt, o_p0_rdata, o_p0_rvalid, o_p0_wdone,
    input  i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, i_p1_wmask,
    output o_p1_gnt, o_p1_rdata, o_p1_rvalid, o_p1_wdone,
    output o_busy,
    output o_app_addr, o_app_cmd, o_app_en,
    input  i_app_rdy,
    output o_app_wdf_data, o_app_wdf_mask, o_app_wdf_wren, o_app_wdf_end,
    input  i_app_wdf_rdy,
    input  i_app_rd_data, i_app_rd_data_valid, i_app_rd_data_end
  );

  modport master (
    output i_init_calib_complete,
    output i_p0_req, i_p0_we, i_p0_addr, i_p0_wdata, i_p0_wmask,
    input  o_p0_gnt, o_p0_rdata, o_p0_rvalid, o_p0_wdone,
    output i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, i_p1_wmask,
    input  o_p1_gnt, o_p1_rdata, o_p1_rvalid, o_p1_wdone,
    input  o_busy,
    input  o_app_addr, o_app_cmd, o_app_en,
    output i_app_rdy,
    input  o_app_wdf_data, o_app_wdf_mask, o_app_wdf_wren, o_app_wdf_end,
    output i_app_wdf_rdy,
    output i_app_rd_data, i_app_rd_data_valid, i_app_rd_data_end
  );
endinterface

// File: rtl/ddr_app_arbiter.sv
// Two-port, one-transaction-at-a-time sequencer for the MIG 7-series app port.
// Define DDR_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to port 0.
module ddr_app_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                clk_166M66,
  input  logic                mcu_sys_rst_n,
  ddr_app_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_CMD  = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_WAIT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_WIDTH-1:0] r_wmask;
  logic [2:0]            r_cmd;
  logic                  r_gnt0, r_gnt1;
  logic                  r_wdone0, r_wdone1;
  logic                  r_rvalid0, r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
  logic                  r_busy;
  logic                  r_en;
  logic                  r_wren;

  logic                  w_win;
  logic                  w_win_we;
  logic                  w_latch;
  logic                  w_rd_cap;
  logic                  w_gnt0, w_gnt1;
  logic                  w_wdone0, w_wdone1;
  logic                  w_rvalid0, w_rvalid1;
  logic                  w_en_nxt;
  logic                  w_wren_nxt;
  logic                  w_unused_rd_end;

  // Single-beat transactions never need the end-of-burst marker.
  assign w_unused_rd_end = bus.i_app_rd_data_end;

`ifdef DDR_ARB_ROUND_ROBIN_EN
  logic r_last;
  assign w_win = (bus.i_p0_req & bus.i_p1_req) ? ~r_last : bus.i_p1_req;
`else
  assign w_win = ~bus.i_p0_req;
`endif
  assign w_win_we = w_win ? bus.i_p1_we : bus.i_p0_we;

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Handshake strobes are registered, so each wait state first arms its strobe
  // and then holds it until the MIG samples it together with its ready.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_rd_cap    = 1'b0;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_wdone0    = 1'b0;
    w_wdone1    = 1'b0;
    w_rvalid0   = 1'b0;
    w_rvalid1   = 1'b0;
    w_en_nxt    = 1'b0;
    w_wren_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_init_calib_complete && (bus.i_p0_req || bus.i_p1_req)) begin
          w_latch     = 1'b1;
          w_gnt0      = ~w_win;
          w_gnt1      = w_win;
          w_state_nxt = w_win_we ? S_WR_DATA : S_RD_CMD;
        end
      end
      S_WR_DATA: begin
        w_wren_nxt = 1'b1;
        if (r_wren && bus.i_app_wdf_rdy) begin
          w_wren_nxt  = 1'b0;
          w_en_nxt    = 1'b1;
          w_state_nxt = S_WR_CMD;
        end
      end
      S_WR_CMD: begin
        w_en_nxt = 1'b1;
        if (r_en && bus.i_app_rdy) begin
          w_en_nxt    = 1'b0;
          w_wdone0    = ~r_idx;
          w_wdone1    = r_idx;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_CMD: begin
        w_en_nxt = 1'b1;
        if (r_en && bus.i_app_rdy) begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.i_app_rd_data_valid) begin
          w_rd_cap    = 1'b1;
          w_rvalid0   = ~r_idx;
          w_rvalid1   = r_idx;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      r_idx     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_cmd     <= 3'b000;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_wdone0  <= 1'b0;
      r_wdone1  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_busy    <= 1'b0;
      r_en      <= 1'b0;
      r_wren    <= 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      r_last    <= 1'b1;
`endif
    end else begin
      r_gnt0    <= w_gnt0;
      r_gnt1    <= w_gnt1;
      r_wdone0  <= w_wdone0;
      r_wdone1  <= w_wdone1;
      r_rvalid0 <= w_rvalid0;
      r_rvalid1 <= w_rvalid1;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_en      <= w_en_nxt;
      r_wren    <= w_wren_nxt;
      if (w_latch) begin
        r_idx   <= w_win;
        r_addr  <= w_win ? bus.i_p1_addr  : bus.i_p0_addr;
        r_wdata <= w_win ? bus.i_p1_wdata : bus.i_p0_wdata;
        r_wmask <= w_win ? bus.i_p1_wmask : bus.i_p0_wmask;
        r_cmd   <= w_win_we ? 3'b000 : 3'b001;
`ifdef DDR_ARB_ROUND_ROBIN_EN
        r_last  <= w_win;
`endif
      end
      if (w_rd_cap) begin
        if (r_idx) r_rdata1 <= bus.i_app_rd_data;
        else       r_rdata0 <= bus.i_app_rd_data;
      end
    end
  end

  assign bus.o_p0_gnt       = r_gnt0;
  assign bus.o_p1_gnt       = r_gnt1;
  assign bus.o_p0_wdone     = r_wdone0;
  assign bus.o_p1_wdone     = r_wdone1;
  assign bus.o_p0_rvalid    = r_rvalid0;
  assign bus.o_p1_rvalid    = r_rvalid1;
  assign bus.o_p0_rdata     = r_rdata0;
  assign bus.o_p1_rdata     = r_rdata1;
  assign bus.o_busy         = r_busy;
  assign bus.o_app_addr     = r_addr;
  assign bus.o_app_cmd      = r_cmd;
  assign bus.o_app_en       = r_en;
  assign bus.o_app_wdf_data = r_wdata;
  assign bus.o_app_wdf_mask = r_wmask;
  assign bus.o_app_wdf_wren = r_wren;
  assign bus.o_app_wdf_end  = r_wren;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Directed and randomized bench for ddr_app_arbiter with a behavioural MIG and memory model.
module tb_ddr_app_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #3 clk = ~clk;

  ddr_app_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  ddr_app_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk_166M66    (clk),
    .mcu_sys_rst_n (rst_n),
    .bus           (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] ddr     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_rdata [2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gnt_of(input int p);
    return (p != 0) ? bus.o_p1_gnt : bus.o_p0_gnt;
  endfunction
  function automatic logic wdone_of(input int p);
    return (p != 0) ? bus.o_p1_wdone : bus.o_p0_wdone;
  endfunction
  function automatic logic rvalid_of(input int p);
    return (p != 0) ? bus.o_p1_rvalid : bus.o_p0_rvalid;
  endfunction
  function automatic logic [DW-1:0] rdata_of(input int p);
    return (p != 0) ? bus.o_p1_rdata : bus.o_p0_rdata;
  endfunction

  // Byte-enable merge with MIG polarity: mask bit 1 keeps the old byte.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < MW; i++) if (!m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ddr_rd(input logic [AW-1:0] a);
    return ddr.exists(a) ? ddr[a] : '0;
  endfunction
  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic set_req(input int p, input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (p == 0) begin
      bus.i_p0_req = req; bus.i_p0_we = we; bus.i_p0_addr = a; bus.i_p0_wdata = d; bus.i_p0_wmask = m;
    end else begin
      bus.i_p1_req = req; bus.i_p1_we = we; bus.i_p1_addr = a; bus.i_p1_wdata = d; bus.i_p1_wmask = m;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    bus.i_init_calib_complete = 1'b1;
    bus.i_app_rdy             = 1'b1;
    bus.i_app_wdf_rdy         = 1'b1;
    bus.i_app_rd_data         = '0;
    bus.i_app_rd_data_valid   = 1'b0;
    bus.i_app_rd_data_end     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string t);
    chk({t, "_ctl"}, DW'({bus.o_p0_gnt, bus.o_p1_gnt, bus.o_p0_rvalid, bus.o_p1_rvalid,
                          bus.o_p0_wdone, bus.o_p1_wdone, bus.o_busy, bus.o_app_en,
                          bus.o_app_wdf_wren, bus.o_app_wdf_end}), '0);
    chk({t, "_cmd"},   DW'(bus.o_app_cmd), '0);
    chk({t, "_addr"},  DW'(bus.o_app_addr), '0);
    chk({t, "_wdata"}, bus.o_app_wdf_data, '0);
    chk({t, "_wmask"}, DW'(bus.o_app_wdf_mask), '0);
    chk({t, "_rdata0"}, bus.o_p0_rdata, '0);
    chk({t, "_rdata1"}, bus.o_p1_rdata, '0);
  endtask

  // One single-port transaction against the behavioural MIG with random ready stalls.
  task automatic do_txn(input int p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    logic          done, stray, data_acc;
    logic [DW-1:0] pend_d;
    logic [MW-1:0] pend_m;
    logic [AW-1:0] rd_a;
    int            rd_dly;
    done = 1'b0; stray = 1'b0; data_acc = !we; rd_dly = 0;
    pend_d = '0; pend_m = '0; rd_a = '0;
    set_req(p, 1'b1, we, a, d, m);
    step();
    chkb("rnd_gnt", gnt_of(p), 1'b1);
    chkb("rnd_gnt_other", gnt_of(1 - p), 1'b0);
    set_req(p, 1'b0, 1'b0, '0, '0, '0);
    for (int c = 0; c < 200 && !done; c++) begin
      bus.i_app_wdf_rdy       = ($urandom_range(0, 2) != 0);
      bus.i_app_rdy           = ($urandom_range(0, 2) != 0);
      bus.i_app_rd_data_valid = 1'b0;
      if (bus.o_app_wdf_wren) begin
        chk("rnd_wdf_data", bus.o_app_wdf_data, d);
        chk("rnd_wdf_mask", DW'(bus.o_app_wdf_mask), DW'(m));
        if (bus.i_app_wdf_rdy) begin
          pend_d = bus.o_app_wdf_data; pend_m = bus.o_app_wdf_mask; data_acc = 1'b1;
        end
      end
      if (bus.o_app_en) begin
        chkb("rnd_en_after_data", data_acc, 1'b1);
        chk("rnd_app_addr", DW'(bus.o_app_addr), DW'(a));
        chk("rnd_app_cmd", DW'(bus.o_app_cmd), we ? DW'(0) : DW'(1));
        if (bus.i_app_rdy) begin
          if (we) ddr[bus.o_app_addr] = merge(ddr_rd(bus.o_app_addr), pend_d, pend_m);
          else begin rd_a = bus.o_app_addr; rd_dly = $urandom_range(1, 6); end
        end
      end else if (rd_dly > 0) begin
        rd_dly--;
        if (rd_dly == 0) begin
          bus.i_app_rd_data_valid = 1'b1;
          bus.i_app_rd_data       = ddr_rd(rd_a);
        end
      end
      step();
      if (gnt_of(0) || gnt_of(1) || wdone_of(1 - p) || rvalid_of(1 - p)) stray = 1'b1;
      if (we ? rvalid_of(p) : wdone_of(p)) stray = 1'b1;
      if (we ? wdone_of(p) : rvalid_of(p)) done = 1'b1;
    end
    bus.i_app_rd_data_valid = 1'b0;
    if (we) ref_mem[a] = merge(ref_rd(a), d, m);
    else    exp_rdata[p] = ref_rd(a);
    chkb("rnd_done", done, 1'b1);
    chkb("rnd_stray_pulse", stray, 1'b0);
    chkb("rnd_busy_at_done", bus.o_busy, 1'b0);
    chk("rnd_rdata_p", rdata_of(p), exp_rdata[p]);
    chk("rnd_rdata_other", rdata_of(1 - p), exp_rdata[1 - p]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a5, wd, cdat;
    int            cnt, wcnt, last, w;
    logic          seen;
    int            gq[$];
    int            exp_seq[4];

    idle_inputs();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    a5   = {16{8'hA5}};
    wd   = {4{32'h1357_9BDF}};
    cdat = {4{32'hC0DE_0001}};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    step();
    chk_reset_outputs("rst_release");

    // Single read, port 0
    set_req(0, 1'b1, 1'b0, 28'h0000100, '0, '0);
    step();
    chkb("rd_gnt0", bus.o_p0_gnt, 1'b1);
    chkb("rd_gnt1", bus.o_p1_gnt, 1'b0);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    step();
    chkb("rd_en_t1", bus.o_app_en, 1'b1);
    chk("rd_cmd", DW'(bus.o_app_cmd), DW'(1));
    chk("rd_addr", DW'(bus.o_app_addr), DW'(28'h0000100));
    step();
    chkb("rd_en_drop", bus.o_app_en, 1'b0);
    chkb("rd_busy_wait", bus.o_busy, 1'b1);
    cnt = 0;
    repeat (3) begin step(); if (bus.o_p0_rvalid) cnt++; end
    chk("rd_no_early_rvalid", DW'(cnt), '0);
    step();
    bus.i_app_rd_data_valid = 1'b1;
    bus.i_app_rd_data       = a5;
    step();
    bus.i_app_rd_data_valid = 1'b0;
    chkb("rd_rvalid0", bus.o_p0_rvalid, 1'b1);
    chk("rd_rdata0", bus.o_p0_rdata, a5);
    chk("rd_p1_quiet", DW'({bus.o_p1_gnt, bus.o_p1_rvalid, bus.o_p1_wdone}), '0);
    chk("rd_rdata1", bus.o_p1_rdata, '0);
    chkb("rd_busy_done", bus.o_busy, 1'b0);
    step();
    chkb("rd_rvalid_pulse", bus.o_p0_rvalid, 1'b0);
    exp_rdata[0] = a5;

    // Stray read data while idle
    bus.i_app_rd_data_valid = 1'b1;
    bus.i_app_rd_data       = {4{32'hDEAD_BEEF}};
    cnt = 0;
    repeat (3) begin step(); if (bus.o_p0_rvalid || bus.o_p1_rvalid || bus.o_busy) cnt++; end
    bus.i_app_rd_data_valid = 1'b0;
    chk("stray_no_rvalid", DW'(cnt), '0);
    chk("stray_rdata0", bus.o_p0_rdata, a5);
    chk("stray_rdata1", bus.o_p1_rdata, '0);

    // Write on port 1 with wdf_rdy stalled 3 cycles and calib dropping mid-transaction
    bus.i_app_wdf_rdy = 1'b0;
    set_req(1, 1'b1, 1'b1, 28'h0ABCDE0, wd, 16'h000F);
    step();
    chkb("wr_gnt1", bus.o_p1_gnt, 1'b1);
    chkb("wr_gnt0", bus.o_p0_gnt, 1'b0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    bus.i_init_calib_complete = 1'b0;
    step();
    chkb("wr_wren_t1", bus.o_app_wdf_wren, 1'b1);
    wcnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.o_app_en) seen = 1'b1;
      else begin
        if (bus.o_app_wdf_wren) begin
          wcnt++;
          chk("wr_wdf_data", bus.o_app_wdf_data, wd);
          chk("wr_wdf_mask", DW'(bus.o_app_wdf_mask), DW'(16'h000F));
          chkb("wr_wdf_end", bus.o_app_wdf_end, 1'b1);
        end
        bus.i_app_wdf_rdy = (wcnt >= 4);
        step();
      end
    end
    bus.i_app_wdf_rdy = 1'b1;
    chkb("wr_en_seen", seen, 1'b1);
    chk("wr_wren_cycles", DW'(wcnt), DW'(4));
    chkb("wr_wren_off", bus.o_app_wdf_wren, 1'b0);
    chk("wr_cmd", DW'(bus.o_app_cmd), '0);
    chk("wr_addr", DW'(bus.o_app_addr), DW'(28'h0ABCDE0));
    step();
    chkb("wr_wdone1", bus.o_p1_wdone, 1'b1);
    chkb("wr_wdone0", bus.o_p0_wdone, 1'b0);
    chkb("wr_en_off", bus.o_app_en, 1'b0);
    chkb("wr_busy_done", bus.o_busy, 1'b0);
    step();
    chkb("wr_wdone_pulse", bus.o_p1_wdone, 1'b0);

    // Calibration low blocks grants
    set_req(0, 1'b1, 1'b1, 28'h0000040, wd, '0);
    cnt = 0;
    repeat (20) begin
      step();
      if (bus.o_p0_gnt || bus.o_p1_gnt || bus.o_app_en || bus.o_busy) cnt++;
    end
    chk("calib_low_idle", DW'(cnt), '0);
    bus.i_init_calib_complete = 1'b1;
    step();
    chkb("calib_gnt", bus.o_p0_gnt, 1'b1);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin step(); if (bus.o_p0_wdone) seen = 1'b1; end
    chkb("calib_wdone", seen, 1'b1);

    // Reset while waiting for read data, then late read data
    set_req(0, 1'b1, 1'b0, 28'h0000200, '0, '0);
    step();
    chkb("rst_rd_gnt", bus.o_p0_gnt, 1'b1);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    step();
    chkb("rst_rd_en", bus.o_app_en, 1'b1);
    step();
    chkb("rst_rd_waiting", bus.o_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    step();
    step();
    rst_n = 1'b1;
    bus.i_app_rd_data_valid = 1'b1;
    bus.i_app_rd_data       = {4{32'h1234_5678}};
    step();
    bus.i_app_rd_data_valid = 1'b0;
    chk_reset_outputs("rst_late_valid");
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;

    // Both ports request continuously: four grants
    last = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
      w = 1 - last;
`else
      w = 0;
`endif
      exp_seq[i] = w;
      last = w;
    end
    set_req(0, 1'b1, 1'b0, 28'h0000300, '0, '0);
    set_req(1, 1'b1, 1'b0, 28'h0000310, '0, '0);
    bus.i_app_rd_data       = cdat;
    bus.i_app_rd_data_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60 && gq.size() < 4; c++) begin
      step();
      if (bus.o_p0_gnt && bus.o_p1_gnt) cnt++;
      if (bus.o_p0_gnt) gq.push_back(0);
      if (bus.o_p1_gnt) gq.push_back(1);
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    for (int c = 0; c < 20 && bus.o_busy; c++) step();
    bus.i_app_rd_data_valid = 1'b0;
    chk("arb_double_gnt", DW'(cnt), '0);
    chk("arb_count", DW'(gq.size()), DW'(4));
    for (int i = 0; i < 4; i++) begin
      chk("arb_winner", DW'((i < gq.size()) ? gq[i] : -1), DW'(exp_seq[i]));
      exp_rdata[exp_seq[i]] = cdat;
    end
    chkb("arb_idle", bus.o_busy, 1'b0);
    chk("arb_rdata0", bus.o_p0_rdata, exp_rdata[0]);
    chk("arb_rdata1", bus.o_p1_rdata, exp_rdata[1]);

    // Randomized single-port traffic against the memory model
    for (int t = 0; t < 24; t++) begin
      int            p;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [MW-1:0] m;
      p  = int'($urandom_range(0, 1));
      we = ($urandom_range(0, 1) != 0);
      a  = 28'h0200000 + AW'($urandom_range(0, 3) << 3);
      d  = {$urandom, $urandom, $urandom, $urandom};
      m  = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom);
      do_txn(p, we, a, d, m);
      repeat (int'($urandom_range(0, 2))) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
